// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: accepts one RV32I load/store at a time,
// waits LATENCY cycles, then issues a single-cycle response.
// The backing store is a word-organised little-endian RAM.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned     IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W:0] ByteLimit = (ADDR_W + 1)'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [2:0]          funct3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                err_q;

  logic                accept;
  logic                req_err;
  logic [IdxW-1:0]     idx_q;
  logic [31:0]         rd_word;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [31:0]         load_val;
  logic [3:0]          wr_be;
  logic [31:0]         wr_lanes;

  logic [31:0]         mem [DEPTH_WORDS];

  assign accept = req_valid && req_ready;
  assign idx_q  = addr_q[IdxW+1:2];

  // Request validation: alignment, range (no wrap of high bits) and funct3 legality
  always_comb begin
    req_err = 1'b0;
    if ({1'b0, req_addr} >= ByteLimit) req_err = 1'b1;
    case (req_funct3[1:0])
      2'd1:    if (req_addr[0]) req_err = 1'b1;
      2'd2:    if (req_addr[1:0] != 2'd0) req_err = 1'b1;
      2'd3:    req_err = 1'b1;
      default: ;
    endcase
    // Stores only have SB/SH/SW; loads additionally allow LBU/LHU.
    if (req_we ? req_funct3[2] : (req_funct3[2] && req_funct3[1])) req_err = 1'b1;
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; WAIT lasts exactly LATENCY cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd1) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Capture the request on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      err_q    <= req_err;
    end
  end

  // Load lane extraction and store lane replication
  always_comb begin
    rd_word = mem[idx_q];
    rd_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    rd_half = rd_word[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
      3'd4:    load_val = {24'd0, rd_byte};
      3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
      3'd5:    load_val = {16'd0, rd_half};
      default: load_val = rd_word;
    endcase
    case (funct3_q[1:0])
      2'd0: begin
        wr_be    = 4'b0001 << addr_q[1:0];
        wr_lanes = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        wr_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        wr_be    = 4'b1111;
        wr_lanes = wdata_q;
      end
    endcase
  end

  // Store commit on the edge ending RESP; reset in RESP discards the store
  always_ff @(posedge clk) begin
    if (!rst && state_q == StResp && we_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx_q][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  // Handshake and response outputs
  always_comb begin
    req_ready = (state_q == StIdle) && !rst;
    busy      = (state_q != StIdle);
    rsp_valid = (state_q == StResp);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !we_q && !err_q) ? load_val : 32'd0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=0, sharing a
// request bus with per-instance valids, checked against a byte-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;  // 0: LATENCY=2 instance, 1: LATENCY=0 instance
  logic        q_valid;
  logic        q_we;
  logic [2:0]  q_f3;
  logic [31:0] q_addr;
  logic [31:0] q_wdata;

  logic        ready2, rsp_valid2, err2, busy2;
  logic [31:0] rdata2;
  logic        ready0, rsp_valid0, err0, busy0;
  logic [31:0] rdata0;

  logic        o_ready, o_rsp_valid, o_err, o_busy;
  logic [31:0] o_rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mm [0:1][0:1023];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .ADDR_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(q_valid && !sel), .req_ready(ready2),
    .req_we(q_we), .req_funct3(q_f3), .req_addr(q_addr), .req_wdata(q_wdata),
    .rsp_valid(rsp_valid2), .rsp_rdata(rdata2), .rsp_err(err2), .busy(busy2)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0), .ADDR_W(32)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(q_valid && sel), .req_ready(ready0),
    .req_we(q_we), .req_funct3(q_f3), .req_addr(q_addr), .req_wdata(q_wdata),
    .rsp_valid(rsp_valid0), .rsp_rdata(rdata0), .rsp_err(err0), .busy(busy0)
  );

  assign o_ready     = sel ? ready0     : ready2;
  assign o_rsp_valid = sel ? rsp_valid0 : rsp_valid2;
  assign o_err       = sel ? err0       : err2;
  assign o_busy      = sel ? busy0      : busy2;
  assign o_rdata     = sel ? rdata0     : rdata2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: byte-addressed memory, RV32I access rules
  function automatic void ref_model(input int d, input logic we, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    output logic e, output logic [31:0] rd);
    int unsigned size;
    logic        legal;
    logic [31:0] v;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    e     = !legal || (a >= 32'd1024) || ((a % size) != 0);
    rd    = 32'd0;
    if (!e) begin
      if (we) begin
        for (int i = 0; i < int'(size); i++) mm[d][a + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < int'(size); i++) v[8*i +: 8] = mm[d][a + i];
        if (!f3[2] && size < 4 && v[8*size-1]) begin
          for (int i = int'(size); i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        rd = v;
      end
    end
  endfunction

  // One full transaction on the selected instance; checks timing, returns response
  task automatic xact(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic e, output logic [31:0] rd);
    int   n;
    int   lat;
    logic ok;
    @(negedge clk);
    sel = (d == 1); q_we = we; q_f3 = f3; q_addr = a; q_wdata = wd; q_valid = 1'b1;
    #1;
    n = 0;
    while (!o_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    q_valid = 1'b0;
    lat = 0;
    ok  = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (o_ready !== 1'b0 || o_busy !== 1'b1) ok = 1'b0;
    end while (!o_rsp_valid && lat < 40);
    chk("rsp_latency", 32'(lat), (d == 1) ? 32'd1 : 32'd3);
    chk("busy_not_ready", {31'd0, ok}, 32'd1);
    e  = o_err;
    rd = o_rdata;
    @(negedge clk);
    chk("rsp_one_cycle", {29'd0, o_rsp_valid, o_ready, o_busy}, 32'b010);
  endtask

  task automatic run(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd);
    logic        e, e_exp;
    logic [31:0] rd, rd_exp;
    ref_model(d, we, f3, a, wd, e_exp, rd_exp);
    xact(d, we, f3, a, wd, e, rd);
    chk($sformatf("rnd_err d%0d we%0d f3=%0d a=%h", d, we, f3, a), {31'd0, e}, {31'd0, e_exp});
    chk($sformatf("rnd_rdata d%0d we%0d f3=%0d a=%h", d, we, f3, a), rd, rd_exp);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [23];

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e, e_m;
    logic [31:0] rd, rd_m;
    logic        ok;
    int          acc, rsp;

    rst = 1'b1; sel = 1'b0; q_valid = 1'b0; q_we = 1'b0; q_f3 = 3'd0;
    q_addr = 32'd0; q_wdata = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    q_valid = 1'b1;
    #1;
    chk("ready_in_reset", {30'd0, ready2, ready0}, 32'd0);
    chk("idle_outputs_in_reset",
        {28'd0, rsp_valid2, err2, busy2, busy0}, 32'd0);
    chk("rdata_in_reset", rdata2 | rdata0, 32'd0);
    q_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {30'd0, ready2, ready0}, 32'd3);

    // Preload both RAMs so every model byte is known
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 256; w++) begin
        logic [31:0] v;
        v = $urandom;
        ref_model(d, 1'b1, 3'd2, 32'(w * 4), v, e_m, rd_m);
        xact(d, 1'b1, 3'd2, 32'(w * 4), v, e, rd);
        if (e !== 1'b0 || rd !== 32'd0) chk("preload_store_rsp", {e, rd[30:0]}, 32'd0);
      end
    end

    // Directed vectors on the LATENCY=2 instance
    tbl[0]  = '{1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 3'd0, 32'h11,  32'h00000080, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 3'd0, 32'h11,  32'h0,        1'b0, 32'hFFFFFF80};
    tbl[4]  = '{1'b0, 3'd4, 32'h11,  32'h0,        1'b0, 32'h00000080};
    tbl[5]  = '{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'hDEAD80EF};
    tbl[6]  = '{1'b0, 3'd1, 32'h12,  32'h0,        1'b0, 32'hFFFFDEAD};
    tbl[7]  = '{1'b0, 3'd5, 32'h12,  32'h0,        1'b0, 32'h0000DEAD};
    tbl[8]  = '{1'b0, 3'd1, 32'h10,  32'h0,        1'b0, 32'hFFFF80EF};
    tbl[9]  = '{1'b0, 3'd2, 32'h13,  32'h0,        1'b1, 32'h0};
    tbl[10] = '{1'b1, 3'd1, 32'h11,  32'h0000BEEF, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'hDEAD80EF};
    tbl[12] = '{1'b0, 3'd2, 32'h400, 32'h0,        1'b1, 32'h0};
    tbl[13] = '{1'b0, 3'd3, 32'h10,  32'h0,        1'b1, 32'h0};
    tbl[14] = '{1'b1, 3'd3, 32'h10,  32'hFFFFFFFF, 1'b1, 32'h0};
    tbl[15] = '{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'hDEAD80EF};
    tbl[16] = '{1'b0, 3'd2, 32'hFFFFFFFC, 32'h0,   1'b1, 32'h0};
    tbl[17] = '{1'b0, 3'd6, 32'h10,  32'h0,        1'b1, 32'h0};
    tbl[18] = '{1'b1, 3'd1, 32'h12,  32'h00001234, 1'b0, 32'h0};
    tbl[19] = '{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'h123480EF};
    tbl[20] = '{1'b0, 3'd0, 32'h13,  32'h0,        1'b0, 32'h00000012};
    tbl[21] = '{1'b1, 3'd2, 32'h3FC, 32'hA5A5A5A5, 1'b0, 32'h0};
    tbl[22] = '{1'b0, 3'd2, 32'h3FC, 32'h0,        1'b0, 32'hA5A5A5A5};

    for (int i = 0; i < 23; i++) begin
      ref_model(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, e_m, rd_m);
      xact(0, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, e, rd);
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, tbl[i].err});
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rdata);
    end

    // Reset during WAIT (k=1) and during RESP (k=3) aborts the store
    for (int k = 1; k <= 3; k += 2) begin
      logic [31:0] a;
      a = (k == 1) ? 32'h20 : 32'h24;
      @(negedge clk);
      sel = 1'b0; q_we = 1'b1; q_f3 = 3'd2; q_addr = a; q_wdata = 32'h12345678; q_valid = 1'b1;
      #1;
      chk($sformatf("abort%0d_ready", k), {31'd0, ready2}, 32'd1);
      @(posedge clk); #1;
      q_valid = 1'b0;
      repeat (k) @(negedge clk);
      chk($sformatf("abort%0d_busy_before", k), {31'd0, busy2}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk($sformatf("abort%0d_post_reset", k), {29'd0, ready2, busy2, rsp_valid2}, 32'b100);
      ok = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (rsp_valid2 !== 1'b0) ok = 1'b0;
      end
      chk($sformatf("abort%0d_no_rsp", k), {31'd0, ok}, 32'd1);
      run(0, 1'b0, 3'd2, a, 32'd0);
    end

    // Randomized traffic on both instances
    for (int n = 0; n < 300; n++) begin
      int          r;
      logic [31:0] a;
      logic [2:0]  f3;
      logic        we;
      r  = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h400 + $urandom_range(0, 7);
      else             a = $urandom_range(0, 1023);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3[1:0] = {1'b0, a[0]} ^ 2'($urandom_range(0, 2));
      we = ($urandom_range(0, 2) == 0);
      run(int'($urandom_range(0, 1)), we, f3, a, $urandom);
    end

    // LATENCY=0: valid held high accepts every other cycle, one response per accept
    ref_model(1, 1'b0, 3'd2, 32'h10, 32'd0, e_m, rd_m);
    @(negedge clk);
    sel = 1'b1; q_we = 1'b0; q_f3 = 3'd2; q_addr = 32'h10; q_valid = 1'b1;
    #1;
    acc = 0; rsp = 0; ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ready0 !== (i % 2 == 0)) ok = 1'b0;
      if (ready0) acc++;
      if (rsp_valid0) begin
        rsp++;
        chk($sformatf("b2b_rdata%0d", i), rdata0, rd_m);
      end
      @(negedge clk); #1;
    end
    q_valid = 1'b0;
    repeat (3) begin
      if (rsp_valid0) rsp++;
      @(negedge clk); #1;
    end
    chk("b2b_ready_pattern", {31'd0, ok}, 32'd1);
    chk("b2b_accepts", 32'(acc), 32'd10);
    chk("b2b_rsp_per_accept", 32'(rsp), 32'(acc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
